// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the iterative multiply/divide sequencer:
//   operation encodings carried on op_i and the sequencer state encoding.
//   No ports (package).
package muldiv_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_MULU = 2'b00;
  localparam logic [OP_W-1:0] OP_DIVU = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL  = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if
//   Request/response bundle between the datapath (master) and the
//   multiply/divide sequencer (slave).
//   master drives: start_i, op_i, src1_i, src2_i
//   slave drives : ready_o, busy_o, done_o, hi_o, lo_o, div_zero_o
import muldiv_pkg::*;

interface muldiv_if #(parameter int WIDTH = 32);

  logic              start_i;
  logic [OP_W-1:0]   op_i;
  logic [WIDTH-1:0]  src1_i;
  logic [WIDTH-1:0]  src2_i;
  logic              ready_o;
  logic              busy_o;
  logic              done_o;
  logic [WIDTH-1:0]  hi_o;
  logic [WIDTH-1:0]  lo_o;
  logic              div_zero_o;

  modport master (
    output start_i, op_i, src1_i, src2_i,
    input  ready_o, busy_o, done_o, hi_o, lo_o, div_zero_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i,
    output ready_o, busy_o, done_o, hi_o, lo_o, div_zero_o
  );

endinterface

// File: rtl/muldiv_addsub.sv
// muldiv_addsub
//   W-bit adder/subtractor shared by the multiply (add) and restoring
//   divide (subtract) steps.
//   a, b  : operands
//   sub   : 1 -> a - b, 0 -> a + b
//   sum   : W-bit result
//   cout  : carry out; when subtracting, 1 means a >= b (no borrow)
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
//   Iterative multiply/divide sequencer: one shift-add (MUL) or
//   restoring shift-subtract (DIV) step per cycle, then one FIX cycle
//   for sign correction and result load.
//   clk_i  : clock, rising edge
//   rst_n  : synchronous reset, active low
//   bus    : muldiv_if.slave (start_i/op_i/src1_i/src2_i in;
//            ready_o/busy_o/done_o/hi_o/lo_o/div_zero_o out)
//   Build option: define MULDIV_SIGNED_EN to make ops 10/11 signed;
//   otherwise op_i[1] has no effect.
//
//   state   | meaning
//   --------+---------------------------------------------
//   ST_IDLE | ready for a request, results held
//   ST_RUN  | WIDTH iteration steps, cnt WIDTH-1 down to 0
//   ST_FIX  | sign correction, load hi_o/lo_o, pulse done
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic    clk_i,
  input  logic    rst_n,
  muldiv_if.slave bus
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q;   // MUL: product high half; DIV: remainder
  logic [WIDTH-1:0] acc_lo_q;   // MUL: multiplier/product low; DIV: dividend/quotient
  logic [WIDTH-1:0] opnd_q;     // MUL: multiplicand; DIV: divisor
  logic             is_div_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             div_zero_q;

  logic             op_div;
  logic             op_signed;
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;

  assign op_div = (bus.op_i == OP_DIVU) || (bus.op_i == OP_DIV);

`ifdef MULDIV_SIGNED_EN
  assign op_signed = (bus.op_i == OP_MUL) || (bus.op_i == OP_DIV);
`else
  assign op_signed = 1'b0;
`endif

  // Signed ops run on magnitudes; the signs are kept for the FIX cycle.
  assign src1_neg = op_signed & bus.src1_i[WIDTH-1];
  assign src2_neg = op_signed & bus.src2_i[WIDTH-1];
  assign src1_mag = src1_neg ? -bus.src1_i : bus.src1_i;
  assign src2_mag = src2_neg ? -bus.src2_i : bus.src2_i;

  // DIV presents the left-shifted remainder {rem, next dividend bit};
  // MUL presents the zero-extended high accumulator.
  logic [WIDTH:0] as_a;
  logic [WIDTH:0] as_b;
  logic [WIDTH:0] as_sum;
  logic           as_cout;

  assign as_a = is_div_q ? {acc_hi_q, acc_lo_q[WIDTH-1]} : {1'b0, acc_hi_q};
  assign as_b = {1'b0, opnd_q};

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (is_div_q),
    .sum  (as_sum),
    .cout (as_cout)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.ready_o = 1'b0;
    bus.busy_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        bus.busy_o = 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        bus.busy_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sign correction. The remainder follows the dividend's sign, which also
  // makes a divide-by-zero return the original dividend on hi.
  logic                 neg_prod;
  logic [2*WIDTH-1:0]   prod_raw;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  always_comb begin
    neg_prod = neg_a_q ^ neg_b_q;
    prod_raw = {acc_hi_q, acc_lo_q};
    prod_fix = neg_prod ? -prod_raw : prod_raw;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      res_hi = neg_a_q ? -acc_hi_q : acc_hi_q;
      if (dz_q) res_lo = '1;
      else      res_lo = neg_prod ? -acc_lo_q : acc_lo_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            cnt_q      <= CNT_W'(WIDTH - 1);
            acc_hi_q   <= '0;
            acc_lo_q   <= op_div ? src1_mag : src2_mag;
            opnd_q     <= op_div ? src2_mag : src1_mag;
            is_div_q   <= op_div;
            neg_a_q    <= src1_neg;
            neg_b_q    <= src2_neg;
            dz_q       <= op_div && (bus.src2_i == '0);
            div_zero_q <= 1'b0;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (is_div_q) begin
            acc_hi_q <= as_cout ? as_sum[WIDTH-1:0] : as_a[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], as_cout};
          end else begin
            acc_hi_q <= acc_lo_q[0] ? as_sum[WIDTH:1] : {1'b0, acc_hi_q[WIDTH-1:1]};
            acc_lo_q <= {(acc_lo_q[0] ? as_sum[0] : acc_hi_q[0]), acc_lo_q[WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          hi_q       <= res_hi;
          lo_q       <= res_lo;
          div_zero_q <= dz_q;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.done_o     = done_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.div_zero_o = div_zero_q;

endmodule
